dm_slot_allocator: RTL and testbench
====================================

// Module: dm_slot_allocator
// PURPOSE
//   Synthesizable multi-channel fixed-size slot allocator for the dm memory-model family.
//   - Hands out slot addresses to NUM_CH requesters through a round-robin arbiter.
//   - Accepts frees by address, checks them, and supports a bulk flush.
//   - Sits between traffic generators and the memory model; the DPI allocator stays as the behavioural reference.
// PARAMETERS
//   NUM_CH     2      number of alloc request channels (>=1)
//   NUM_SLOTS  16     slots in the pool (>=2)
//   ADDR_W     64     address width
//   BASE_ADDR  'h1    address of slot 0
//   SLOT_BYTES 1      bytes per slot; power of two
// PORTS
//   clock          in   1              single clock, rising edge
//   reset_n        in   1              asynchronous reset, active low
//   alloc_req      in   NUM_CH         per-channel request; hold until alloc_ack
//   alloc_ack      out  NUM_CH         one-cycle grant pulse
//   alloc_addr     out  NUM_CH*ADDR_W  granted address, valid while alloc_ack
//   free_valid     in   1              free request, one per cycle
//   free_addr      in   ADDR_W         address to free
//   free_err       out  1              one-cycle pulse: the previous free was rejected
//   flush          in   1              release all slots
//   full           out  1              no free slot
//   empty          out  1              no slot in use
//   used_cnt       out  $clog2(NUM_SLOTS+1)  slots in use
//   hwm_cnt        out  $clog2(NUM_SLOTS+1)  high-water mark (stats)
//   alloc_total    out  32             allocations since reset (stats)
// BEHAVIOUR
//   Reset
//   - reset_n low: used bitmap, alloc_ack, alloc_addr, free_err, used_cnt, hwm_cnt and alloc_total clear to 0.
//   - empty=1, full=0, RR pointer=ch0, FSM=RUN.
//   - Takes effect asynchronously: a pending ack is dropped at once.
//   Allocation (1-cycle latency)
//   - Eligible channel: alloc_req=1 and its alloc_ack not currently high.
//   - Each edge in RUN with !full: pick one eligible channel, round-robin starting after the last grant.
//   - Pick the lowest-index free slot; set its used bit.
//   - Next cycle: that channel's alloc_ack=1 and alloc_addr=BASE_ADDR+idx*SLOT_BYTES.
//   - At most one grant per cycle. A single channel holding req gets one grant every 2 cycles.
//   - full: requests stall, no ack, no error.
//   Free
//   - Legal: addr>=BASE_ADDR, (addr-BASE_ADDR)%SLOT_BYTES==0, idx<NUM_SLOTS, and slot used.
//   - Legal free: clear the slot at the edge. Illegal free: state unchanged, free_err=1 next cycle.
//   - Same-cycle alloc+free: the allocator uses the pre-free bitmap; the freed slot is reusable next cycle.
//   - Free of a slot granted in the same cycle is illegal.
//   Counters and flags
//   - used_cnt += grant - legal_free, registered.
//   - full=(used_cnt==NUM_SLOTS); empty=(used_cnt==0).
//   FSM RUN/FLUSH
//   - RUN->FLUSH: flush=1. In FLUSH: no grants, frees ignored (no free_err).
//   - FLUSH->RUN: one cycle after flush drops; the bitmap is cleared and used_cnt=0 on FLUSH entry.
//   - Acks granted before the flush edge still complete; those slots are released by the flush.
// CONFIGURATION
//   DM_SLOT_ALLOC_STATS_EN
//   - Defined: hwm_cnt tracks max(used_cnt) since reset; it is not cleared by flush.
//   - Defined: alloc_total increments per grant and wraps at 2^32.
//   - Undefined: hwm_cnt and alloc_total are tied to 0; no stats flops.
// TESTING (defaults: NUM_CH=2, NUM_SLOTS=16, BASE_ADDR=1, SLOT_BYTES=1)
//   1. ch0 req held, ch1 idle, 16 grants -> addrs 0x1..0x10 in order, ack every 2nd cycle; then full=1, used_cnt=16, further req stalls.
//   2. ch0+ch1 req held from reset -> acks alternate ch0,ch1 on consecutive cycles; addrs 0x1,0x2,0x3,...
//   3. pool full, free 0x5 -> used_cnt=15, no free_err; next grant addr=0x5.
//   4. free 0x5 twice -> 2nd free_err=1, used_cnt unchanged; free 0x0 and free 0x11 -> free_err=1 each.
//   5. 10 slots used, flush for 1 cycle -> used_cnt=0, empty=1, then next grant addr=0x1; with STATS_EN, hwm_cnt=10.
//   6. reset_n low mid-cycle while alloc_ack=1 -> alloc_ack=0 before the next edge, used_cnt=0, next grant after release addr=0x1.

Source files
------------

// File: rtl/dm_slot_allocator.sv
// rtl/dm_slot_allocator.sv - round-robin multi-channel fixed-size slot allocator with checked frees and flush
// Optional stats (hwm_cnt, alloc_total) enabled by defining DM_SLOT_ALLOC_STATS_EN.
module dm_slot_allocator #(
    parameter int                NUM_CH     = 2,
    parameter int                NUM_SLOTS  = 16,
    parameter int                ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h1,
    parameter int                SLOT_BYTES = 1
) (
    input  logic                               i_clock,
    input  logic                               i_reset_n,
    input  logic [NUM_CH-1:0]                  i_alloc_req,
    output logic [NUM_CH-1:0]                  o_alloc_ack,
    output logic [NUM_CH*ADDR_W-1:0]           o_alloc_addr,
    input  logic                               i_free_valid,
    input  logic [ADDR_W-1:0]                  i_free_addr,
    output logic                               o_free_err,
    input  logic                               i_flush,
    output logic                               o_full,
    output logic                               o_empty,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     o_used_cnt,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     o_hwm_cnt,
    output logic [31:0]                        o_alloc_total
);

    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SHIFT = $clog2(SLOT_BYTES);
    localparam logic [ADDR_W-1:0] LP_MASK  = ADDR_W'(SLOT_BYTES - 1);
    localparam logic [ADDR_W-1:0] LP_SLOTS = ADDR_W'(NUM_SLOTS);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [NUM_SLOTS-1:0]      r_used;
    logic [NUM_SLOTS-1:0]      w_used_next;
    logic [NUM_CH-1:0]         r_ack;
    logic [NUM_CH*ADDR_W-1:0]  r_addr;
    logic                      r_free_err;
    logic [CNT_W-1:0]          r_used_cnt;
    logic [CNT_W-1:0]          w_cnt_next;
    logic [CH_W-1:0]           r_rr_ptr;

    logic                      w_run;
    logic                      w_flush_entry;
    logic [NUM_CH-1:0]         w_elig;
    logic                      w_grant_vld;
    logic [CH_W-1:0]           w_grant_ch;
    logic                      w_slot_vld;
    logic [IDX_W-1:0]          w_slot_idx;
    logic                      w_do_grant;
    logic [ADDR_W-1:0]         w_grant_addr;
    logic [ADDR_W-1:0]         w_free_off;
    logic [ADDR_W-1:0]         w_free_slot;
    logic                      w_free_legal;
    logic                      w_do_free;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:   if (i_flush)  w_state_next = ST_FLUSH;
            ST_FLUSH: if (!i_flush) w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    // The flush edge itself blocks grants and frees so the cleared bitmap stays consistent.
    assign w_run         = (r_state == ST_RUN) && !i_flush;
    assign w_flush_entry = (r_state == ST_RUN) && i_flush;

    assign w_elig = i_alloc_req & ~r_ack;

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_grant_vld && w_elig[(int'(r_rr_ptr) + k) % NUM_CH]) begin
                w_grant_vld = 1'b1;
                w_grant_ch  = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        w_slot_vld = 1'b0;
        w_slot_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!w_slot_vld && !r_used[i]) begin
                w_slot_vld = 1'b1;
                w_slot_idx = IDX_W'(i);
            end
        end
    end

    assign w_do_grant   = w_run && !o_full && w_grant_vld && w_slot_vld;
    assign w_grant_addr = BASE_ADDR + (ADDR_W'(w_slot_idx) << SHIFT);

    // Legality is judged on the pre-grant bitmap, so freeing a slot granted this edge is rejected.
    assign w_free_off   = i_free_addr - BASE_ADDR;
    assign w_free_slot  = w_free_off >> SHIFT;
    assign w_free_legal = (i_free_addr >= BASE_ADDR)
                       && ((w_free_off & LP_MASK) == '0)
                       && (w_free_slot < LP_SLOTS)
                       && r_used[w_free_slot[IDX_W-1:0]];
    assign w_do_free    = i_free_valid && w_run && w_free_legal;

    always_comb begin
        w_used_next = r_used;
        if (w_flush_entry) begin
            w_used_next = '0;
        end else begin
            if (w_do_grant) w_used_next[w_slot_idx] = 1'b1;
            if (w_do_free)  w_used_next[w_free_slot[IDX_W-1:0]] = 1'b0;
        end
    end

    always_comb begin
        w_cnt_next = r_used_cnt;
        if (w_flush_entry) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_used_cnt + CNT_W'(w_do_grant) - CNT_W'(w_do_free);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_used     <= '0;
            r_used_cnt <= '0;
            r_ack      <= '0;
            r_addr     <= '0;
            r_free_err <= 1'b0;
            r_rr_ptr   <= '0;
        end else begin
            r_used     <= w_used_next;
            r_used_cnt <= w_cnt_next;
            r_free_err <= i_free_valid && w_run && !w_free_legal;
            r_ack      <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_do_grant && (w_grant_ch == CH_W'(c))) begin
                    r_ack[c]                    <= 1'b1;
                    r_addr[c*ADDR_W +: ADDR_W]  <= w_grant_addr;
                end
            end
            if (w_do_grant) begin
                r_rr_ptr <= (w_grant_ch == CH_W'(NUM_CH - 1)) ? '0 : w_grant_ch + 1'b1;
            end
        end
    end

    assign o_alloc_ack  = r_ack;
    assign o_alloc_addr = r_addr;
    assign o_free_err   = r_free_err;
    assign o_used_cnt   = r_used_cnt;
    assign o_full       = (r_used_cnt == CNT_W'(NUM_SLOTS));
    assign o_empty      = (r_used_cnt == '0);

`ifdef DM_SLOT_ALLOC_STATS_EN
    logic [CNT_W-1:0] r_hwm;
    logic [31:0]      r_total;

    // High-water mark survives flush; only reset clears it.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hwm   <= '0;
            r_total <= '0;
        end else begin
            if (w_cnt_next > r_hwm) r_hwm <= w_cnt_next;
            if (w_do_grant)         r_total <= r_total + 32'd1;
        end
    end

    assign o_hwm_cnt     = r_hwm;
    assign o_alloc_total = r_total;
`else
    assign o_hwm_cnt     = '0;
    assign o_alloc_total = '0;
`endif

endmodule

// File: tb/tb_dm_slot_allocator.sv
// tb/tb_dm_slot_allocator.sv - scoreboard testbench for dm_slot_allocator
module tb_dm_slot_allocator;

    localparam int NUM_CH    = 2;
    localparam int NUM_SLOTS = 16;
    localparam int ADDR_W    = 64;
    localparam int CNT_W     = 5;
`ifdef DM_SLOT_ALLOC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_CH-1:0]         alloc_req = '0;
    logic [NUM_CH-1:0]         alloc_ack;
    logic [NUM_CH*ADDR_W-1:0]  alloc_addr;
    logic                      free_valid = 1'b0;
    logic [ADDR_W-1:0]         free_addr = '0;
    logic                      free_err;
    logic                      flush = 1'b0;
    logic                      full;
    logic                      empty;
    logic [CNT_W-1:0]          used_cnt;
    logic [CNT_W-1:0]          hwm_cnt;
    logic [31:0]               alloc_total;

    typedef struct {
        int                ch;
        logic [ADDR_W-1:0] addr;
    } ack_t;

    ack_t ack_q[$];
    bit   err_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_acks = 0;
    logic prev_free;
    int   n0;

    dm_slot_allocator #(
        .NUM_CH(NUM_CH), .NUM_SLOTS(NUM_SLOTS), .ADDR_W(ADDR_W),
        .BASE_ADDR(64'h1), .SLOT_BYTES(1)
    ) dut (
        .i_clock(clk),
        .i_reset_n(rst_n),
        .i_alloc_req(alloc_req),
        .o_alloc_ack(alloc_ack),
        .o_alloc_addr(alloc_addr),
        .i_free_valid(free_valid),
        .i_free_addr(free_addr),
        .o_free_err(free_err),
        .i_flush(flush),
        .o_full(full),
        .o_empty(empty),
        .o_used_cnt(used_cnt),
        .o_hwm_cnt(hwm_cnt),
        .o_alloc_total(alloc_total)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_free <= 1'b0;
        else        prev_free <= free_valid;
    end

    always @(negedge clk) begin
        ack_t e;
        bit   ee;
        if (rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (alloc_ack[c]) begin
                    n_acks++;
                    checks++;
                    if (ack_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ack: ch%0d addr=%0h, no grant expected", c, alloc_addr[c*ADDR_W +: ADDR_W]);
                    end else begin
                        e = ack_q.pop_front();
                        if (e.ch != c || e.addr != alloc_addr[c*ADDR_W +: ADDR_W]) begin
                            errors++;
                            $display("FAIL grant: got ch%0d addr=%0h, expected ch%0d addr=%0h",
                                     c, alloc_addr[c*ADDR_W +: ADDR_W], e.ch, e.addr);
                        end
                    end
                end
            end
            if (prev_free) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL free_err_queue: free seen with no expectation, free_err=%0b", free_err);
                end else begin
                    ee = err_q.pop_front();
                    if (free_err !== ee) begin
                        errors++;
                        $display("FAIL free_err: got %0b expected %0b", free_err, ee);
                    end
                end
            end else if (free_err) begin
                checks++;
                errors++;
                $display("FAIL free_err_spurious: got 1 expected 0");
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_ack(input int ch, input logic [ADDR_W-1:0] a);
        ack_t e;
        e.ch   = ch;
        e.addr = a;
        ack_q.push_back(e);
    endtask

    task automatic do_free(input logic [ADDR_W-1:0] a, input bit exp_err);
        free_valid = 1'b1;
        free_addr  = a;
        err_q.push_back(exp_err);
        @(negedge clk);
        free_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        alloc_req  = '0;
        free_valid = 1'b0;
        flush      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ack", alloc_ack, 0);
        check("rst_used", used_cnt, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_free_err", free_err, 0);
        check("rst_hwm", hwm_cnt, 0);
        check("rst_total", alloc_total, 0);

        // Two channels from reset: alternating grants on consecutive cycles
        alloc_req = 2'b11;
        for (int i = 0; i < 6; i++) exp_ack(i % 2, 64'(i + 1));
        n0 = n_acks;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        alloc_req = '0;
        #1;
        check("rr_ack_count", n_acks - n0, 6);
        check("rr_used", used_cnt, 6);

        // Single channel fills the pool at one grant per two cycles
        apply_reset();
        n0 = n_acks;
        alloc_req = 2'b01;
        for (int i = 0; i < 16; i++) exp_ack(0, 64'(i + 1));
        repeat (16) @(negedge clk);
        #1;
        check("fill_rate", n_acks - n0, 8);
        repeat (20) @(negedge clk);
        #1;
        check("fill_ack_count", n_acks - n0, 16);
        check("fill_used", used_cnt, 16);
        check("fill_full", full, 1);
        check("fill_empty", empty, 0);
        check("fill_hwm", hwm_cnt, STATS ? 16 : 0);
        check("fill_total", alloc_total, STATS ? 16 : 0);
        alloc_req = '0;

        // Legal free, double free and out-of-range frees
        do_free(64'h5, 1'b0);
        #1;
        check("free_used", used_cnt, 15);
        check("free_full", full, 0);
        do_free(64'h5, 1'b1);
        do_free(64'h0, 1'b1);
        do_free(64'h11, 1'b1);
        #1;
        check("bad_free_used", used_cnt, 15);
        n0 = n_acks;
        exp_ack(0, 64'h5);
        alloc_req = 2'b01;
        @(negedge clk);
        alloc_req = '0;
        #1;
        check("refill_ack_count", n_acks - n0, 1);
        check("refill_used", used_cnt, 16);

        // Free while full: grant waits a cycle; freeing the slot being granted is rejected
        n0 = n_acks;
        exp_ack(0, 64'h7);
        alloc_req = 2'b01;
        do_free(64'h7, 1'b0);
        #1;
        check("prefree_no_grant", n_acks - n0, 0);
        check("prefree_used", used_cnt, 15);
        do_free(64'h7, 1'b1);
        alloc_req = '0;
        #1;
        check("samecycle_ack_count", n_acks - n0, 1);
        check("samecycle_used", used_cnt, 16);

        // Flush with 10 slots in use; a free during flush is ignored
        apply_reset();
        alloc_req = 2'b01;
        for (int i = 0; i < 10; i++) exp_ack(0, 64'(i + 1));
        repeat (20) @(negedge clk);
        alloc_req = '0;
        #1;
        check("preflush_used", used_cnt, 10);
        flush      = 1'b1;
        free_valid = 1'b1;
        free_addr  = 64'h0;
        err_q.push_back(1'b0);
        @(negedge clk);
        flush      = 1'b0;
        free_valid = 1'b0;
        n0 = n_acks;
        exp_ack(0, 64'h1);
        alloc_req = 2'b01;
        #1;
        check("flush_used", used_cnt, 0);
        check("flush_empty", empty, 1);
        check("flush_hwm", hwm_cnt, STATS ? 10 : 0);
        repeat (3) @(negedge clk);
        alloc_req = '0;
        #1;
        check("postflush_ack_count", n_acks - n0, 1);
        check("postflush_used", used_cnt, 1);
        check("postflush_hwm", hwm_cnt, STATS ? 10 : 0);
        check("postflush_total", alloc_total, STATS ? 11 : 0);

        // Asynchronous reset while an ack is high
        apply_reset();
        alloc_req = 2'b01;
        exp_ack(0, 64'h1);
        @(negedge clk);
        #2;
        check("pre_areset_ack", alloc_ack, 2'b01);
        rst_n = 1'b0;
        #1;
        check("areset_ack", alloc_ack, 0);
        check("areset_used", used_cnt, 0);
        repeat (2) @(negedge clk);
        n0 = n_acks;
        exp_ack(0, 64'h1);
        rst_n = 1'b1;
        @(negedge clk);
        alloc_req = '0;
        #1;
        check("post_areset_ack_count", n_acks - n0, 1);
        check("post_areset_used", used_cnt, 1);

        repeat (2) @(negedge clk);
        check("pending_grants", ack_q.size(), 0);
        check("pending_free_err", err_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
